// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one small FIFO per result producer, drained onto a
// registered broadcast port by a round-robin scan over the non-empty FIFO heads.
module cdb_arbiter #(
    parameter int unsigned NUM_SRC        = 3,
    parameter int unsigned ROB_WIDTH_BIT  = 4,
    parameter int unsigned FIFO_DEPTH_BIT = 1
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             rdy_in,
    input  logic                             clear,
    input  logic [NUM_SRC-1:0]               src_valid,
    input  logic [NUM_SRC*ROB_WIDTH_BIT-1:0] src_rob_id,
    input  logic [NUM_SRC*32-1:0]            src_value,
    output logic [NUM_SRC-1:0]               src_ready,
    output logic                             cdb_valid,
    output logic [ROB_WIDTH_BIT-1:0]         cdb_rob_id,
    output logic [31:0]                      cdb_value,
    output logic [$clog2(NUM_SRC)-1:0]       cdb_src
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_BIT;
    localparam int unsigned SRC_W = $clog2(NUM_SRC);
    localparam int unsigned CNT_W = FIFO_DEPTH_BIT + 1;
    localparam int unsigned ENT_W = ROB_WIDTH_BIT + 32;

    logic [ENT_W-1:0]          r_mem   [NUM_SRC][DEPTH];
    logic [FIFO_DEPTH_BIT-1:0] r_head  [NUM_SRC];
    logic [FIFO_DEPTH_BIT-1:0] r_tail  [NUM_SRC];
    logic [CNT_W-1:0]          r_count [NUM_SRC];
    logic [SRC_W-1:0]          r_ptr;

    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pop;
    logic               w_found;
    logic [SRC_W-1:0]   w_win;
    logic [SRC_W-1:0]   w_ptr_next;
    logic [ENT_W-1:0]   w_head_data;
    int unsigned        w_idx;

    // Ready looks at the count only: a full FIFO refuses even while it pops.
    always_comb begin
        src_ready = '0;
        w_push    = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = (r_count[i] < CNT_W'(DEPTH)) && rdy_in && !clear;
            w_push[i]    = src_valid[i] && src_ready[i];
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            w_idx = 32'(r_ptr) + k;
            if (w_idx >= NUM_SRC) begin
                w_idx = w_idx - NUM_SRC;
            end
            if (!w_found && (r_count[w_idx] != '0)) begin
                w_found = 1'b1;
                w_win   = SRC_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            w_pop[i] = w_found && (w_win == SRC_W'(i));
        end
        w_ptr_next  = (w_win == SRC_W'(NUM_SRC - 1)) ? '0 : w_win + 1'b1;
        w_head_data = r_mem[w_win][r_head[w_win]];
    end

    // Storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk_in) begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_tail[i]] <= {src_rob_id[i*ROB_WIDTH_BIT +: ROB_WIDTH_BIT],
                                        src_value[i*32 +: 32]};
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                r_head[i]  <= '0;
                r_tail[i]  <= '0;
                r_count[i] <= '0;
            end
            r_ptr     <= '0;
            cdb_valid <= 1'b0;
            if (rst_in) begin
                cdb_rob_id <= '0;
                cdb_value  <= '0;
                cdb_src    <= '0;
            end
        end else if (rdy_in) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (w_push[i]) begin
                    r_tail[i] <= r_tail[i] + 1'b1;
                end
                if (w_pop[i]) begin
                    r_head[i] <= r_head[i] + 1'b1;
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + 1'b1;
                    2'b01:   r_count[i] <= r_count[i] - 1'b1;
                    default: r_count[i] <= r_count[i];
                endcase
            end
            if (w_found) begin
                cdb_valid  <= 1'b1;
                cdb_rob_id <= w_head_data[ENT_W-1:32];
                cdb_value  <= w_head_data[31:0];
                cdb_src    <= w_win;
                r_ptr      <= w_ptr_next;
            end else begin
                cdb_valid  <= 1'b0;
            end
        end
    end

endmodule
